// File: rtl/mips_data_memory_ctrl.sv
// Byte-addressable data memory for the MIPS datapath (LB/LBU/LH/LHU/LW/SB/SH/SW), big-endian lanes.
// Latency: request accepted at edge T, response valid after edge T+1+WAIT_CYCLES.
// Backpressure: one request in flight; response held stable until mem_resp_ready, mem_req_ready low meanwhile.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   mem_req_*           : valid/ready request (write, size, signed, byte addr, right-aligned wdata)
//   mem_resp_*          : valid/ready response (extended rdata, error flag)
module mips_data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_req_write,
  input  logic [1:0]  mem_req_size,
  input  logic        mem_req_signed,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_wdata,
  output logic        mem_resp_valid,
  input  logic        mem_resp_ready,
  output logic [31:0] mem_resp_rdata,
  output logic        mem_resp_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The counter is loaded with the full wait count: the cycle in which it reads
  // zero is the access cycle, which puts the response one edge after the last
  // stall cycle and gives the T+1+WAIT_CYCLES latency, including WAIT_CYCLES=0.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [7:0] mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  access_err;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           load_data;

  assign accept = mem_req_valid && mem_req_ready;
  assign access = (state == WAIT) && (cnt == 4'd0);

  assign a0 = lat_addr[ADDR_WIDTH-1:0];
  assign a1 = a0 + ONE;
  assign a2 = a1 + ONE;
  assign a3 = a2 + ONE;
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    access_err = 1'b0;
    if (lat_size == 2'b11) access_err = 1'b1;
    if (lat_size == 2'b01 && lat_addr[0]) access_err = 1'b1;
    if (lat_size == 2'b10 && lat_addr[1:0] != 2'b00) access_err = 1'b1;
    if (|lat_addr[31:ADDR_WIDTH]) access_err = 1'b1;
  end

  always_comb begin
    load_data = 32'h0;
    case (lat_size)
      2'b00:   load_data = lat_signed ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   load_data = lat_signed ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      2'b10:   load_data = {b0, b1, b2, b3};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = WAIT;
      WAIT:    if (cnt == 4'd0) next_state = RESP;
      RESP:    if (mem_resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      mem_req_ready  <= 1'b1;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= 32'h0;
      mem_resp_error <= 1'b0;
      lat_write      <= 1'b0;
      lat_size       <= 2'b00;
      lat_signed     <= 1'b0;
      lat_addr       <= 32'h0;
      lat_wdata      <= 32'h0;
    end else begin
      state         <= next_state;
      mem_req_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write  <= mem_req_write;
            lat_size   <= mem_req_size;
            lat_signed <= mem_req_signed;
            lat_addr   <= mem_req_addr;
            lat_wdata  <= mem_req_wdata;
            cnt        <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem_resp_valid <= 1'b1;
            mem_resp_error <= access_err;
            mem_resp_rdata <= (access_err || lat_write) ? 32'h0 : load_data;
          end
        end
        RESP: begin
          if (mem_resp_ready) begin
            mem_resp_valid <= 1'b0;
            mem_resp_rdata <= 32'h0;
            mem_resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left out of reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_write && !access_err) begin
      case (lat_size)
        2'b00: mem[a0] <= lat_wdata[7:0];
        2'b01: begin
          mem[a0] <= lat_wdata[15:8];
          mem[a1] <= lat_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= lat_wdata[31:24];
          mem[a1] <= lat_wdata[23:16];
          mem[a2] <= lat_wdata[15:8];
          mem[a3] <= lat_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_memory_ctrl.sv
// Self-checking bench for mips_data_memory_ctrl: scoreboard queue plus response monitor,
// with a second WAIT_CYCLES=0 instance for the short-latency build.
// Stimulus is directed; expected values are hand-computed constants.
module tb_mips_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;

  logic        d0_req_valid, d0_req_ready, d0_req_write, d0_req_signed;
  logic [1:0]  d0_req_size;
  logic [31:0] d0_req_addr, d0_req_wdata;
  logic        d0_resp_valid, d0_resp_ready, d0_resp_error;
  logic [31:0] d0_resp_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mips_data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_write(req_write),
    .mem_req_size(req_size), .mem_req_signed(req_signed), .mem_req_addr(req_addr),
    .mem_req_wdata(req_wdata), .mem_resp_valid(resp_valid), .mem_resp_ready(resp_ready),
    .mem_resp_rdata(resp_rdata), .mem_resp_error(resp_error)
  );

  mips_data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .mem_req_valid(d0_req_valid), .mem_req_ready(d0_req_ready), .mem_req_write(d0_req_write),
    .mem_req_size(d0_req_size), .mem_req_signed(d0_req_signed), .mem_req_addr(d0_req_addr),
    .mem_req_wdata(d0_req_wdata), .mem_resp_valid(d0_resp_valid), .mem_resp_ready(d0_resp_ready),
    .mem_resp_rdata(d0_resp_rdata), .mem_resp_error(d0_resp_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every handshaken response against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h expected=none", resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, {31'b0, resp_error}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic do_req(input string name, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee, input int exp_lat, input bit hold);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=timeout expected=ready", name);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{er, ee, name});
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!hold) begin
      n = 0;
      while (resp_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic d0_req(input string name, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] er);
    @(negedge clk);
    d0_req_valid = 1'b1; d0_req_write = wr; d0_req_size = sz; d0_req_signed = sg;
    d0_req_addr = ad; d0_req_wdata = wd;
    @(posedge clk);
    #1 d0_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_valid_lat1"}, {31'b0, d0_resp_valid}, 32'd1);
    check({name, "_rdata"}, d0_resp_rdata, er);
    check({name, "_err"}, {31'b0, d0_resp_error}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_ready_back"}, {31'b0, d0_req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    d0_req_valid = 1'b0; d0_req_write = 1'b0; d0_req_size = 2'b00; d0_req_signed = 1'b0;
    d0_req_addr = 32'h0; d0_req_wdata = 32'h0; d0_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", {31'b0, resp_error}, 32'd0);
    reset = 1'b0;

    // Basic store/load and lane placement
    do_req("sw10",  1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0, 2, 0);
    do_req("lw10",  0, 2'b10, 0, 32'h10, 32'h0,        32'h11223344, 0, 2, 0);
    do_req("lb13",  0, 2'b00, 1, 32'h13, 32'h0,        32'h00000044, 0, 2, 0);
    do_req("sb10",  1, 2'b00, 0, 32'h10, 32'h000000F0, 32'h0,        0, 2, 0);
    do_req("lb10",  0, 2'b00, 1, 32'h10, 32'h0,        32'hFFFFFFF0, 0, 2, 0);
    do_req("lbu10", 0, 2'b00, 0, 32'h10, 32'h0,        32'h000000F0, 0, 2, 0);
    do_req("lw10b", 0, 2'b10, 0, 32'h10, 32'h0,        32'hF0223344, 0, 2, 0);
    do_req("sh12",  1, 2'b01, 0, 32'h12, 32'h00008001, 32'h0,        0, 2, 0);
    do_req("lh12",  0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF8001, 0, 2, 0);
    do_req("lhu12", 0, 2'b01, 0, 32'h12, 32'h0,        32'h00008001, 0, 2, 0);
    do_req("lw10c", 0, 2'b10, 0, 32'h10, 32'h0,        32'hF0228001, 0, 2, 0);

    // Error cases: none may touch memory at 0x10
    do_req("lw11_mis",  0, 2'b10, 0, 32'h11,  32'h0,        32'h0, 1, 2, 0);
    do_req("lh13_mis",  0, 2'b01, 1, 32'h13,  32'h0,        32'h0, 1, 2, 0);
    do_req("sw402",     1, 2'b10, 0, 32'h402, 32'h0BADBAD0, 32'h0, 1, 2, 0);
    do_req("sw400_oor", 1, 2'b10, 0, 32'h400, 32'h0BADBAD0, 32'h0, 1, 2, 0);
    do_req("sz11_st",   1, 2'b11, 0, 32'h10,  32'h0BADBAD0, 32'h0, 1, 2, 0);
    do_req("sh11_mis",  1, 2'b01, 0, 32'h11,  32'h0000ABCD, 32'h0, 1, 2, 0);
    do_req("lw10_err",  0, 2'b10, 0, 32'h10,  32'h0,        32'hF0228001, 0, 2, 0);

    // Reset during WAIT aborts the store and produces no response
    do_req("sw20", 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 2, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    do_req("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 2, 0);

    // Response stall: outputs stable, new requests ignored
    resp_ready = 1'b0;
    do_req("stall_lw", 0, 2'b10, 0, 32'h10, 32'h0, 32'hF0228001, 0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, 32'hF0228001);
      check("stall_err", {31'b0, resp_error}, 32'd0);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10;
      req_wdata = 32'h0;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", {31'b0, req_ready}, 32'd1);
    check("release_resp_valid", {31'b0, resp_valid}, 32'd0);
    do_req("lw10_after_stall", 0, 2'b10, 0, 32'h10, 32'h0, 32'hF0228001, 0, 2, 0);

    // WAIT_CYCLES=0 instance
    d0_req("d0_sw8", 1, 2'b10, 0, 32'h8, 32'hA5A51234, 32'h0);
    d0_req("d0_lw8", 0, 2'b10, 0, 32'h8, 32'h0,        32'hA5A51234);
    d0_req("d0_lha", 0, 2'b01, 1, 32'hA, 32'h0,        32'h00001234);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
